// File: rtl/id_ex_reg_pkg.sv
// Shared decode/execute definitions: operation and result-class codes, stall bit
// positions and the field groups carried across the ID/EX boundary.
package id_ex_reg_pkg;

    localparam int STALL_W_DEF   = 6;
    localparam int STALL_IDX_ID  = 2;
    localparam int STALL_IDX_EX  = 3;
    localparam int BUB_CNT_W_DEF = 16;

    localparam logic [7:0] EXE_NOP_OP = 8'h00;
    localparam logic [7:0] EXE_ADD_OP = 8'h20;
    localparam logic [7:0] EXE_SUB_OP = 8'h22;
    localparam logic [7:0] EXE_AND_OP = 8'h24;
    localparam logic [7:0] EXE_OR_OP  = 8'h25;
    localparam logic [7:0] EXE_XOR_OP = 8'h26;
    localparam logic [7:0] EXE_SLT_OP = 8'h2a;
    localparam logic [7:0] EXE_JAL_OP = 8'h50;

    localparam logic [2:0] EXE_RES_NOP         = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC  = 3'b100;
    localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

    typedef enum logic [1:0] {
        PIPE_HOLD    = 2'd0,
        PIPE_CAPTURE = 2'd1,
        PIPE_BUBBLE  = 2'd2
    } pipe_ctl_e;

    typedef struct packed {
        logic [7:0] alu_op;
        logic [2:0] alu_sel;
        logic [4:0] waddr;
        logic       wreg;
        logic       dslot;
        logic       valid;
    } ex_ctrl_t;

    typedef struct packed {
        logic [31:0] reg0;
        logic [31:0] reg1;
        logic [31:0] link_addr;
    } ex_data_t;

    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
        alu_op:  EXE_NOP_OP,
        alu_sel: EXE_RES_NOP,
        waddr:   5'd0,
        wreg:    1'b0,
        dslot:   1'b0,
        valid:   1'b0
    };
    localparam ex_data_t EX_DATA_BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: the controller and ID stage drive it (master), the
// pipeline register consumes the ID side and presents the EX side (slave).
interface id_ex_reg_if #(
    parameter int STALL_W   = 6,
    parameter int BUB_CNT_W = 16
);
    logic [STALL_W-1:0]   stall;
    logic                 flush;
    logic [7:0]           id_alu_op;
    logic [2:0]           id_alu_sel;
    logic [31:0]          id_reg0;
    logic [31:0]          id_reg1;
    logic [4:0]           id_waddr;
    logic                 id_wreg;
    logic [31:0]          id_link_addr;
    logic                 id_is_in_delayslot;
    logic                 id_next_in_delayslot;
    logic [7:0]           ex_alu_op;
    logic [2:0]           ex_alu_sel;
    logic [31:0]          ex_reg0;
    logic [31:0]          ex_reg1;
    logic [4:0]           ex_waddr;
    logic                 ex_wreg;
    logic [31:0]          ex_link_addr;
    logic                 ex_is_in_delayslot;
    logic                 id_in_delayslot_fb;
    logic                 ex_valid;
    logic [BUB_CNT_W-1:0] bubble_cnt;

    modport master (
        output stall, flush, id_alu_op, id_alu_sel, id_reg0, id_reg1, id_waddr,
               id_wreg, id_link_addr, id_is_in_delayslot, id_next_in_delayslot,
        input  ex_alu_op, ex_alu_sel, ex_reg0, ex_reg1, ex_waddr, ex_wreg,
               ex_link_addr, ex_is_in_delayslot, id_in_delayslot_fb, ex_valid,
               bubble_cnt
    );

    modport slave (
        input  stall, flush, id_alu_op, id_alu_sel, id_reg0, id_reg1, id_waddr,
               id_wreg, id_link_addr, id_is_in_delayslot, id_next_in_delayslot,
        output ex_alu_op, ex_alu_sel, ex_reg0, ex_reg1, ex_waddr, ex_wreg,
               ex_link_addr, ex_is_in_delayslot, id_in_delayslot_fb, ex_valid,
               bubble_cnt
    );

endinterface

// File: rtl/id_ex_reg_pipe_field_reg.sv
// Width-parameterised pipeline field register: capture new data, load a bubble
// value, or hold; clears to its reset value asynchronously.
module pipe_field_reg
    import id_ex_reg_pkg::*;
#(
    parameter int         W       = 8,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] BUB_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_,
    input  pipe_ctl_e    ctl_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] field_q;
    logic [W-1:0] field_d;

    always_comb begin
        field_d = field_q;
        case (ctl_i)
            PIPE_CAPTURE: field_d = d_i;
            PIPE_BUBBLE:  field_d = BUB_VAL;
            default:      field_d = field_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            field_q <= RST_VAL;
        end else begin
            field_q <= field_d;
        end
    end

    assign q_o = field_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: decodes flush/stall priority into per-group register
// controls, feeds the delay-slot flag back to ID and counts stall bubbles.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int STALL_W      = STALL_W_DEF,
    parameter int STALL_ID_BIT = STALL_IDX_ID,
    parameter int STALL_EX_BIT = STALL_IDX_EX,
    parameter int BUB_CNT_W    = BUB_CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_,
    id_ex_reg_if.slave  bus
);

    localparam logic [BUB_CNT_W-1:0] CNT_ONE = {{(BUB_CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [BUB_CNT_W-1:0] sat_inc(input logic [BUB_CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    pipe_ctl_e             main_ctl;
    pipe_ctl_e             fb_ctl;
    logic                  stall_bubble;
    ex_ctrl_t              ctrl_d;
    ex_ctrl_t              ctrl_q;
    ex_data_t              data_d;
    ex_data_t              data_q;
    logic                  fb_q;
    logic [BUB_CNT_W-1:0]  bcnt_q;
    logic [BUB_CNT_W-1:0]  bcnt_d;

    // Flush beats everything; an ID-only stall bubbles EX; both stalled holds.
    // The illegal EX-only stall falls through to capture.
    always_comb begin
        main_ctl     = PIPE_HOLD;
        fb_ctl       = PIPE_HOLD;
        stall_bubble = 1'b0;
        if (bus.flush) begin
            main_ctl = PIPE_BUBBLE;
            fb_ctl   = PIPE_BUBBLE;
        end else if (bus.stall[STALL_ID_BIT] && !bus.stall[STALL_EX_BIT]) begin
            main_ctl     = PIPE_BUBBLE;
            stall_bubble = 1'b1;
        end else if (!bus.stall[STALL_ID_BIT]) begin
            main_ctl = PIPE_CAPTURE;
            fb_ctl   = PIPE_CAPTURE;
        end
    end

    always_comb begin
        ctrl_d = '{
            alu_op:  bus.id_alu_op,
            alu_sel: bus.id_alu_sel,
            waddr:   bus.id_waddr,
            wreg:    bus.id_wreg,
            dslot:   bus.id_is_in_delayslot,
            valid:   1'b1
        };
        data_d = '{
            reg0:      bus.id_reg0,
            reg1:      bus.id_reg1,
            link_addr: bus.id_link_addr
        };
        bcnt_d = stall_bubble ? sat_inc(bcnt_q) : bcnt_q;
    end

    pipe_field_reg #(
        .W       ($bits(ex_ctrl_t)),
        .RST_VAL (EX_CTRL_BUBBLE),
        .BUB_VAL (EX_CTRL_BUBBLE)
    ) u_ctrl_reg (
        .clk   (clk),
        .rst_  (rst_),
        .ctl_i (main_ctl),
        .d_i   (ctrl_d),
        .q_o   (ctrl_q)
    );

    pipe_field_reg #(
        .W       ($bits(ex_data_t)),
        .RST_VAL (EX_DATA_BUBBLE),
        .BUB_VAL (EX_DATA_BUBBLE)
    ) u_data_reg (
        .clk   (clk),
        .rst_  (rst_),
        .ctl_i (main_ctl),
        .d_i   (data_d),
        .q_o   (data_q)
    );

    pipe_field_reg #(
        .W       (1),
        .RST_VAL (1'b0),
        .BUB_VAL (1'b0)
    ) u_fb_reg (
        .clk   (clk),
        .rst_  (rst_),
        .ctl_i (fb_ctl),
        .d_i   (bus.id_next_in_delayslot),
        .q_o   (fb_q)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign bus.ex_alu_op          = ctrl_q.alu_op;
    assign bus.ex_alu_sel         = ctrl_q.alu_sel;
    assign bus.ex_waddr           = ctrl_q.waddr;
    assign bus.ex_wreg            = ctrl_q.wreg;
    assign bus.ex_is_in_delayslot = ctrl_q.dslot;
    assign bus.ex_valid           = ctrl_q.valid;
    assign bus.ex_reg0            = data_q.reg0;
    assign bus.ex_reg1            = data_q.reg1;
    assign bus.ex_link_addr       = data_q.link_addr;
    assign bus.id_in_delayslot_fb = fb_q;
    assign bus.bubble_cnt         = bcnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomised scoreboard bench for id_ex_reg: the driver predicts the post-edge
// EX state from the priority rules, the monitor compares it after each edge.
module tb_id_ex_reg;
    import id_ex_reg_pkg::*;

    typedef struct packed {
        logic [7:0]  alu_op;
        logic [2:0]  alu_sel;
        logic [31:0] reg0;
        logic [31:0] reg1;
        logic [4:0]  waddr;
        logic        wreg;
        logic [31:0] link;
        logic        dslot;
        logic        fb;
        logic        valid;
        logic [15:0] bcnt;
    } state_t;

    logic   clk = 1'b0;
    logic   rst_;
    state_t mdl;
    state_t exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;

    always #5 clk = ~clk;

    id_ex_reg_if #(.STALL_W(6), .BUB_CNT_W(16)) bus ();

    id_ex_reg #(
        .STALL_W      (6),
        .STALL_ID_BIT (2),
        .STALL_EX_BIT (3),
        .BUB_CNT_W    (16)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    function automatic state_t observe();
        state_t s;
        s.alu_op  = bus.ex_alu_op;
        s.alu_sel = bus.ex_alu_sel;
        s.reg0    = bus.ex_reg0;
        s.reg1    = bus.ex_reg1;
        s.waddr   = bus.ex_waddr;
        s.wreg    = bus.ex_wreg;
        s.link    = bus.ex_link_addr;
        s.dslot   = bus.ex_is_in_delayslot;
        s.fb      = bus.id_in_delayslot_fb;
        s.valid   = bus.ex_valid;
        s.bcnt    = bus.bubble_cnt;
        return s;
    endfunction

    // Reference: what EX should see after the coming edge, from the ID inputs.
    task automatic predict();
        if (!rst_) begin
            mdl = '0;
        end else if (bus.flush) begin
            mdl.alu_op = EXE_NOP_OP; mdl.alu_sel = EXE_RES_NOP;
            mdl.reg0 = 0; mdl.reg1 = 0; mdl.waddr = 0; mdl.wreg = 0;
            mdl.link = 0; mdl.dslot = 0; mdl.valid = 0; mdl.fb = 0;
        end else if (bus.stall[2] && !bus.stall[3]) begin
            mdl.alu_op = EXE_NOP_OP; mdl.alu_sel = EXE_RES_NOP;
            mdl.reg0 = 0; mdl.reg1 = 0; mdl.waddr = 0; mdl.wreg = 0;
            mdl.link = 0; mdl.dslot = 0; mdl.valid = 0;
            if (mdl.bcnt != 16'hFFFF) mdl.bcnt = mdl.bcnt + 16'd1;
        end else if (!bus.stall[2]) begin
            mdl.alu_op = bus.id_alu_op;   mdl.alu_sel = bus.id_alu_sel;
            mdl.reg0   = bus.id_reg0;     mdl.reg1    = bus.id_reg1;
            mdl.waddr  = bus.id_waddr;    mdl.wreg    = bus.id_wreg;
            mdl.link   = bus.id_link_addr;
            mdl.dslot  = bus.id_is_in_delayslot;
            mdl.fb     = bus.id_next_in_delayslot;
            mdl.valid  = 1'b1;
        end
    endtask

    task automatic step();
        predict();
        exp_q.push_back(mdl);
        @(negedge clk);
    endtask

    task automatic rand_fields();
        bus.id_alu_op            = 8'($urandom);
        bus.id_alu_sel           = 3'($urandom);
        bus.id_reg0              = $urandom;
        bus.id_reg1              = $urandom;
        bus.id_waddr             = 5'($urandom);
        bus.id_wreg              = 1'($urandom);
        bus.id_link_addr         = $urandom;
        bus.id_is_in_delayslot   = 1'($urandom);
        bus.id_next_in_delayslot = 1'($urandom);
    endtask

    task automatic set_ctl(input logic [5:0] st, input logic fl);
        bus.stall = st;
        bus.flush = fl;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            state_t e;
            state_t a;
            e = exp_q.pop_front();
            a = observe();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL ex_state @%0t got=%h want=%h", $time, a, e);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_ === 1'b1) begin
            assert (!(!bus.stall[2] && bus.stall[3])) else begin
                miscompares++;
                $display("FAIL illegal_stall got=%b want=prefix", bus.stall);
            end
        end
    end

    initial begin
        state_t snap;
        int     wait_cyc;
        rst_ = 1'b0;
        mdl  = '0;
        set_ctl(6'b000000, 1'b0);
        rand_fields();

        // Reset held with random inputs and a toggling clock
        repeat (4) begin
            rand_fields();
            set_ctl(6'($urandom_range(0, 1) ? 6'b000000 : 6'b000111), 1'($urandom));
            step();
        end
        rst_ = 1'b1;

        // Plain capture
        set_ctl(6'b000000, 1'b0);
        rand_fields();
        bus.id_alu_op = EXE_OR_OP; bus.id_alu_sel = EXE_RES_LOGIC;
        bus.id_reg0 = 32'h0000_F0F0; bus.id_reg1 = 32'h0F0F_0000;
        bus.id_waddr = 5'd3; bus.id_wreg = 1'b1;
        bus.id_next_in_delayslot = 1'b0;
        step();

        // Load-use bubble, then full hold
        rand_fields();
        set_ctl(6'b000111, 1'b0); step();
        set_ctl(6'b000000, 1'b0); step();
        rand_fields();
        set_ctl(6'b001111, 1'b0); step();

        // Delay-slot feedback survives a bubble, then tags the slot instruction
        set_ctl(6'b000000, 1'b0);
        bus.id_next_in_delayslot = 1'b1; bus.id_is_in_delayslot = 1'b0;
        step();
        rand_fields();
        set_ctl(6'b000111, 1'b0); step();
        rand_fields();
        bus.id_is_in_delayslot = 1'b1; bus.id_next_in_delayslot = 1'b0;
        set_ctl(6'b000000, 1'b0); step();

        // Flush overrides a held stall
        rand_fields();
        bus.id_next_in_delayslot = 1'b1;
        set_ctl(6'b000000, 1'b0); step();
        set_ctl(6'b001111, 1'b0); step();
        set_ctl(6'b001111, 1'b1); step();

        // Asynchronous reset mid-cycle with a real instruction held
        rand_fields();
        set_ctl(6'b000000, 1'b0); step();
        #2;
        snap = observe();
        vectors++;
        if (snap.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_valid got=%b want=1", snap.valid);
        end
        rst_ = 1'b0;
        #1;
        snap = observe();
        vectors++;
        if (snap !== '0) begin
            miscompares++;
            $display("FAIL async_reset got=%h want=0", snap);
        end
        mdl = '0;
        @(negedge clk);
        rst_ = 1'b1;

        // Randomised traffic with legal prefix stalls, flushes and rare resets
        for (int i = 0; i < 1500; i++) begin
            int k;
            rand_fields();
            k = $urandom_range(0, 6);
            set_ctl(6'((7'd1 << k) - 7'd1), ($urandom_range(0, 7) == 0));
            rst_ = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_ = 1'b1;

        // Saturate the bubble counter
        for (int i = 0; i < 65540; i++) begin
            rand_fields();
            set_ctl(6'b000111, 1'b0);
            step();
        end
        vectors++;
        if (bus.bubble_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL bubble_sat got=%h want=ffff", bus.bubble_cnt);
        end
        rand_fields();
        set_ctl(6'b000000, 1'b0); step();
        set_ctl(6'b000111, 1'b0); step();

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the instruction-decode stage and the execute stage of the five-stage MIPS core.
- Captures decoded operation, operands, write-back target, link address and delay-slot flags from ID.
- Honours the global stall vector and flush; inserts bubbles.
- Feeds the branch delay-slot flag back to ID and keeps a saturating bubble counter for performance debug.

Parameters:
- STALL_W, 6, width of global stall vector (PC, IF, ID, EX, MEM, WB).
- STALL_ID_BIT, 2, index of the ID-stage bit in stall.
- STALL_EX_BIT, 3, index of the EX-stage bit in stall.
- BUB_CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- stall  in  STALL_W  per-stage stall request from the controller.
- flush  in  1  exception flush; kills the instruction held here.
- id_alu_op  in  8  decoded ALU operation.
- id_alu_sel  in  3  result-class selector.
- id_reg0  in  32  operand 0.
- id_reg1  in  32  operand 1.
- id_waddr  in  5  destination GPR.
- id_wreg  in  1  GPR write enable.
- id_link_addr  in  32  return address for JAL/JALR/BGEZAL.
- id_is_in_delayslot  in  1  current ID instruction is in a delay slot.
- id_next_in_delayslot  in  1  next instruction is in a delay slot (branch decoded).
- ex_alu_op  out  8  to EX.
- ex_alu_sel  out  3  to EX.
- ex_reg0  out  32  to EX.
- ex_reg1  out  32  to EX.
- ex_waddr  out  5  to EX.
- ex_wreg  out  1  to EX.
- ex_link_addr  out  32  to EX.
- ex_is_in_delayslot  out  1  to EX.
- id_in_delayslot_fb  out  1  feedback to ID: the instruction now entering ID is in a delay slot.
- ex_valid  out  1  1 = a real instruction is in EX; 0 = bubble.
- bubble_cnt  out  BUB_CNT_W  count of inserted bubbles, saturating.

Behaviour:
- Reset (rst_=0, asynchronous): all ex_* outputs 0.
  - ex_alu_op = EXE_NOP_OP (8'h00), ex_alu_sel = EXE_RES_NOP (3'b000).
  - ex_valid = 0, id_in_delayslot_fb = 0, bubble_cnt = 0.
- Priority at each rising clk, highest first:
  1. flush=1: load a bubble; clear id_in_delayslot_fb; bubble_cnt unchanged (a flush is not a stall bubble).
  2. stall[STALL_ID_BIT]=1 and stall[STALL_EX_BIT]=0: load a bubble; bubble_cnt += 1, saturating at all-ones; id_in_delayslot_fb holds.
  3. stall[STALL_ID_BIT]=0: capture.
     - All id_* fields move to the matching ex_* outputs.
     - id_is_in_delayslot goes to ex_is_in_delayslot.
     - id_next_in_delayslot goes to id_in_delayslot_fb.
     - ex_valid = 1.
  4. Otherwise (ID and EX both stalled): hold every output.
- Bubble: ex_alu_op = NOP, ex_alu_sel = NOP, ex_wreg = 0, ex_waddr = 0, ex_reg0/1 = 0, ex_link_addr = 0, ex_is_in_delayslot = 0, ex_valid = 0.
- Latency: exactly one cycle from ID to EX. No combinational path from any input to any output.
- The stall combination stall[ID]=0 with stall[EX]=1 is illegal (the controller stalls a prefix of stages). Required response: the block captures and flags nothing. The bench asserts this combination never occurs.
- Flush during a held stall overrides the hold and bubbles.
- Reset mid-operation discards the held instruction immediately, without waiting for a clock.
- bubble_cnt wraps never; it stays at the maximum value once reached.

Decomposition:
- Shared defines package: EXE_NOP_OP, EXE_RES_NOP, EXE_* op and result-class codes, and the stall bit indices, so the ID, EX and controller blocks use one source.
- One sub-module is natural: pipe_field_reg, a width-parameterised register with capture/bubble/hold controls and a reset value. It is instantiated once per field group.
- The priority decode and bubble_cnt live in id_ex_reg.

Test Plan:
1. Reset: hold rst_=0 with random inputs and toggling clk -> all outputs 0 and ex_valid=0. Assert rst_=0 asynchronously mid-cycle -> outputs clear before the next edge.
2. Capture: stall=0, id_alu_op=8'h25, id_reg0=32'h0000_F0F0, id_reg1=32'h0F0F_0000, id_waddr=5'd3, id_wreg=1 -> next cycle ex_* match the inputs and ex_valid=1.
3. Load-use bubble: stall=6'b000111 for one cycle -> ex_alu_op=0, ex_wreg=0, ex_valid=0, bubble_cnt 0->1. With stall=6'b001111, the previous ex_* values hold and bubble_cnt is unchanged.
4. Delay slot: id_next_in_delayslot=1 with stall=0 -> id_in_delayslot_fb=1 next cycle. A bubble cycle keeps it at 1. The next capture with id_is_in_delayslot=1 -> ex_is_in_delayslot=1.
5. Flush priority: flush=1 with stall=6'b001111 and a valid instruction held -> bubble loaded, id_in_delayslot_fb=0, bubble_cnt unchanged.
6. Saturation: preload bubble_cnt near 16'hFFFF via 70000 consecutive bubble cycles -> bubble_cnt stays at 16'hFFFF.
